uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_queue_if.sv | 17 +
 rtl/uart.sv | 45 ++++
 rtl/uart_tx_queue_fifo.sv | 38 +++
 rtl/uart_tx_queue.sv | 39 +++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width and transmit-queue FSM state encoding.
package uart_pkg;
    localparam int p_width_default = 8;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2;
endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: producer-side and UART-side signals of the transmit queue.
interface uart_tx_queue_if import uart_pkg::*; #(
    parameter int p_depth = 16,
    parameter int p_width = p_width_default
);
    logic [p_width-1:0]       data, tx_data;
    logic                     valid, ready, tx_start, tx_done, empty, full, overflow, busy;
    logic [$clog2(p_depth):0] count;
    modport master (
        output data, valid, tx_done,
        input  ready, tx_start, tx_data, count, empty, full, overflow, busy
    );
    modport slave (
        input  data, valid, tx_done,
        output ready, tx_start, tx_data, count, empty, full, overflow, busy
    );
endinterface

// File: rtl/uart.sv
// uart: 8N1-style serial transmitter; start pulse latches a byte, done pulses when the stop bit ends.
module uart import uart_pkg::*; #(
    parameter int p_clks_per_bit = 434,
    parameter int p_width        = p_width_default
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tx_start,
    input  logic [p_width-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_done
);
    localparam int cw = $clog2(p_clks_per_bit + 1);
    localparam int bw = $clog2(p_width + 3);
    localparam logic [cw-1:0] last_clk   = cw'(p_clks_per_bit - 1);
    localparam logic [bw-1:0] frame_bits = bw'(p_width + 2);
    logic [p_width+1:0] sh;
    logic [bw-1:0]      bits;
    logic [cw-1:0]      cnt;
    assign o_tx = bits == '0 ? 1'b1 : sh[0];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh        <= '1;
            bits      <= '0;
            cnt       <= '0;
            o_tx_done <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            if (bits == '0) begin
                if (i_tx_start) begin
                    sh   <= {1'b1, i_tx_data, 1'b0};
                    bits <= frame_bits;
                    cnt  <= '0;
                end
            end else if (cnt == last_clk) begin
                cnt       <= '0;
                sh        <= {1'b1, sh[p_width+1:1]};
                bits      <= bits - bw'(1);
                o_tx_done <= bits == bw'(1);
            end else begin
                cnt <= cnt + cw'(1);
            end
        end
    end
endmodule

// File: rtl/uart_tx_queue_fifo.sv
// fifo_sync: circular FIFO with wrapping pointers; push ignored when full, pop ignored when empty.
module fifo_sync #(
    parameter int p_depth = 16,
    parameter int p_width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [p_width-1:0]       din,
    output logic [p_width-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(p_depth):0] count
);
    localparam int aw = $clog2(p_depth);
    localparam int cw = aw + 1;
    logic [p_width-1:0] mem [p_depth];
    logic [aw-1:0]      wr_ptr, rd_ptr;
    logic               do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == cw'(p_depth);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + aw'(1);
            if (do_pop) rd_ptr <= rd_ptr + aw'(1);
            count <= count + cw'(do_push) - cw'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through an IDLE/LOAD/WAIT handshake FSM.
module uart_tx_queue import uart_pkg::*; #(
    parameter int p_depth = 16,
    parameter int p_width = p_width_default
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_tx_queue_if.slave q
);
    logic [1:0]         state;
    logic               pop;
    logic [p_width-1:0] head;
    assign pop = state == IDLE && !q.empty;
    fifo_sync #(.p_depth(p_depth), .p_width(p_width)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (q.valid),
        .pop   (pop),
        .din   (q.data),
        .dout  (head),
        .full  (q.full),
        .empty (q.empty),
        .count (q.count)
    );
    assign q.ready    = !q.full;
    assign q.overflow = q.valid & q.full;
    assign q.tx_start = state == LOAD;
    assign q.busy     = state != IDLE;
    // The popped head is captured here and held until the next pop, so tx_data is stable through WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            q.tx_data <= '0;
        end else begin
            if (pop) q.tx_data <= head;
            state <= pop ? LOAD : state == LOAD ? WAIT : state == WAIT && q.tx_done ? IDLE : state;
        end
    end
endmodule
